alu_mdu: RTL and testbench

- Registered, handshaked successor to the combinational ALU.
- Executes all RV32I ALU ops plus RV32M multiply/divide/remainder, with WIDTH generalised.
- Sits in the execute stage. The pipeline stalls on ready_o and consumes results on valid_o/ready_i.
- Single-cycle ops complete in 1 cycle; divide is iterative; multiply is selectable fast or iterative.

---
 rtl/alu_mdu_pkg.sv | 45 ++++
 rtl/alu_mdu_if.sv | 23 ++
 rtl/mdu_div.sv | 72 +++++++
 rtl/alu_mdu.sv | 190 +++++++++++++++++++
 tb/tb_alu_mdu.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared opcodes, FSM state type and op-classification helpers for the
// registered ALU/MDU execute unit.
package alu_mdu_pkg;

  localparam int REG_WIDTH = 32;

  localparam logic [5:0] OP_ALU_ADD    = 6'h00;
  localparam logic [5:0] OP_ALU_SUB    = 6'h01;
  localparam logic [5:0] OP_ALU_AND    = 6'h02;
  localparam logic [5:0] OP_ALU_OR     = 6'h03;
  localparam logic [5:0] OP_ALU_XOR    = 6'h04;
  localparam logic [5:0] OP_ALU_SLL    = 6'h05;
  localparam logic [5:0] OP_ALU_SRL    = 6'h06;
  localparam logic [5:0] OP_ALU_SRA    = 6'h07;
  localparam logic [5:0] OP_ALU_SLT    = 6'h08;
  localparam logic [5:0] OP_ALU_SLTU   = 6'h09;

  localparam logic [5:0] OP_MDU_MUL    = 6'h20;
  localparam logic [5:0] OP_MDU_MULH   = 6'h21;
  localparam logic [5:0] OP_MDU_MULHSU = 6'h22;
  localparam logic [5:0] OP_MDU_MULHU  = 6'h23;
  localparam logic [5:0] OP_MDU_DIV    = 6'h24;
  localparam logic [5:0] OP_MDU_DIVU   = 6'h25;
  localparam logic [5:0] OP_MDU_REM    = 6'h26;
  localparam logic [5:0] OP_MDU_REMU   = 6'h27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_mdu_state_e;

  function automatic logic is_mul(input logic [5:0] op);
    return op inside {OP_MDU_MUL, OP_MDU_MULH, OP_MDU_MULHSU, OP_MDU_MULHU};
  endfunction

  function automatic logic is_div(input logic [5:0] op);
    return op inside {OP_MDU_DIV, OP_MDU_DIVU, OP_MDU_REM, OP_MDU_REMU};
  endfunction

  function automatic logic is_mdu_multicycle(input logic [5:0] op, input logic fast_mul);
    return is_div(op) | (is_mul(op) & ~fast_mul);
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/result handshake bundle between the pipeline and the ALU/MDU.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [5:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] res_o;

  modport master (
    output valid_i, op_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, res_o
  );

  modport slave (
    input  valid_i, op_i, a_i, b_i, ready_i,
    output ready_o, valid_o, res_o
  );
endinterface

// File: rtl/mdu_div.sv
// Iterative restoring unsigned divider: loads on start_i, one quotient bit per
// cycle, pulses done_o after WIDTH iterations.
module mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial
  // subtraction and its borrow; a zero divisor naturally yields all-ones / a.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_diff[WIDTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (flush_i) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start_i) begin
        r_quo  <= dividend_i;
        r_rem  <= '0;
        r_dvs  <= divisor_i;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_fits};
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST_ITER) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign quotient_o  = r_quo;
  assign remainder_o = r_rem;
  assign done_o      = r_done;

endmodule

// File: rtl/alu_mdu.sv
// Registered, handshaked execute unit: RV32I ALU ops plus RV32M multiply /
// divide / remainder, with an optional iterative multiplier.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH,
  parameter int FAST_MUL = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      flush_i,
  alu_mdu_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  alu_mdu_state_e     r_state;
  logic [5:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_valid;
  logic [2*WIDTH-1:0] r_mul_acc;
  logic [2*WIDTH-1:0] r_mul_mcand;
  logic [WIDTH-1:0]   r_mul_mplier;
  logic               r_mul_neg;
  logic [SHW-1:0]     r_mul_cnt;

  logic               w_ready;
  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_fast_prod;
  logic [WIDTH-1:0]   w_alu_res;
  logic [2*WIDTH-1:0] w_mul_acc_next;
  logic [2*WIDTH-1:0] w_mul_prod;
  logic [WIDTH-1:0]   w_mul_res;
  logic               w_div_start;
  logic [WIDTH-1:0]   w_div_quo;
  logic [WIDTH-1:0]   w_div_rem;
  logic               w_div_done;
  logic               w_div_signed;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_div_q_fix;
  logic [WIDTH-1:0]   w_div_r_fix;
  logic [WIDTH-1:0]   w_div_res;

  assign w_ready  = rst_ni & ~flush_i &
                    ((r_state == IDLE) | ((r_state == DONE) & bus.ready_i));
  assign w_accept = bus.valid_i & w_ready;

  // Operand sign handling for the incoming op: magnitudes feed the iterative
  // units, sign-extension feeds the single-cycle product.
  assign w_a_neg = (bus.op_i inside {OP_MDU_MULH, OP_MDU_MULHSU, OP_MDU_DIV, OP_MDU_REM})
                   & bus.a_i[WIDTH-1];
  assign w_b_neg = (bus.op_i inside {OP_MDU_MULH, OP_MDU_DIV, OP_MDU_REM})
                   & bus.b_i[WIDTH-1];
  assign w_a_mag = w_a_neg ? -bus.a_i : bus.a_i;
  assign w_b_mag = w_b_neg ? -bus.b_i : bus.b_i;

  assign w_fast_prod = {{WIDTH{w_a_neg}}, bus.a_i} * {{WIDTH{w_b_neg}}, bus.b_i};

  always_comb begin
    w_alu_res = '0;
    case (bus.op_i)
      OP_ALU_ADD:    w_alu_res = bus.a_i + bus.b_i;
      OP_ALU_SUB:    w_alu_res = bus.a_i - bus.b_i;
      OP_ALU_AND:    w_alu_res = bus.a_i & bus.b_i;
      OP_ALU_OR:     w_alu_res = bus.a_i | bus.b_i;
      OP_ALU_XOR:    w_alu_res = bus.a_i ^ bus.b_i;
      OP_ALU_SLL:    w_alu_res = bus.a_i << bus.b_i[SHW-1:0];
      OP_ALU_SRL:    w_alu_res = bus.a_i >> bus.b_i[SHW-1:0];
      OP_ALU_SRA:    w_alu_res = $signed(bus.a_i) >>> bus.b_i[SHW-1:0];
      OP_ALU_SLT:    w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a_i) < $signed(bus.b_i))};
      OP_ALU_SLTU:   w_alu_res = {{(WIDTH-1){1'b0}}, (bus.a_i < bus.b_i)};
      OP_MDU_MUL:    w_alu_res = w_fast_prod[WIDTH-1:0];
      OP_MDU_MULH,
      OP_MDU_MULHSU,
      OP_MDU_MULHU:  w_alu_res = w_fast_prod[2*WIDTH-1:WIDTH];
      default:       w_alu_res = '0;
    endcase
  end

  // Shift-add multiplier works on magnitudes; the sign is restored on the
  // final iteration so the result lands in the same cycle.
  assign w_mul_acc_next = r_mul_acc + (r_mul_mplier[0] ? r_mul_mcand : '0);
  assign w_mul_prod     = r_mul_neg ? -w_mul_acc_next : w_mul_acc_next;
  assign w_mul_res      = (r_op == OP_MDU_MUL) ? w_mul_prod[WIDTH-1:0]
                                               : w_mul_prod[2*WIDTH-1:WIDTH];

  assign w_div_start = w_accept & is_div(bus.op_i);

  mdu_div #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .start_i     (w_div_start),
    .dividend_i  (w_a_mag),
    .divisor_i   (w_b_mag),
    .quotient_o  (w_div_quo),
    .remainder_o (w_div_rem),
    .done_o      (w_div_done)
  );

  // Sign fix-up; a zero divisor bypasses it so signed ops also give all-ones / a.
  // The most-negative / -1 case falls out of the magnitude arithmetic.
  assign w_div_signed = r_op inside {OP_MDU_DIV, OP_MDU_REM};
  assign w_b_zero     = (r_b == '0);
  assign w_div_q_fix  = (w_div_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & ~w_b_zero)
                        ? -w_div_quo : w_div_quo;
  assign w_div_r_fix  = w_b_zero ? r_a
                        : ((w_div_signed & r_a[WIDTH-1]) ? -w_div_rem : w_div_rem);
  assign w_div_res    = (r_op inside {OP_MDU_DIV, OP_MDU_DIVU}) ? w_div_q_fix : w_div_r_fix;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_valid      <= 1'b0;
      r_res        <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_mul_acc    <= '0;
      r_mul_mcand  <= '0;
      r_mul_mplier <= '0;
      r_mul_neg    <= 1'b0;
      r_mul_cnt    <= '0;
    end else if (flush_i) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if ((r_state == DONE) && bus.ready_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
          if (w_accept) begin
            r_op         <= bus.op_i;
            r_a          <= bus.a_i;
            r_b          <= bus.b_i;
            r_mul_acc    <= '0;
            r_mul_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mul_mplier <= w_b_mag;
            r_mul_neg    <= w_a_neg ^ w_b_neg;
            r_mul_cnt    <= '0;
            if (is_mdu_multicycle(bus.op_i, FAST_MUL != 0)) begin
              r_state <= BUSY;
              r_valid <= 1'b0;
            end else begin
              r_state <= DONE;
              r_valid <= 1'b1;
              r_res   <= w_alu_res;
            end
          end
        end
        BUSY: begin
          if (is_div(r_op)) begin
            if (w_div_done) begin
              r_res   <= w_div_res;
              r_valid <= 1'b1;
              r_state <= DONE;
            end
          end else begin
            r_mul_acc    <= w_mul_acc_next;
            r_mul_mcand  <= r_mul_mcand << 1;
            r_mul_mplier <= r_mul_mplier >> 1;
            r_mul_cnt    <= r_mul_cnt + 1'b1;
            if (r_mul_cnt == LAST_ITER) begin
              r_res   <= w_mul_res;
              r_valid <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.valid_o = r_valid;
  assign bus.res_o   = r_res;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised and directed checks of alu_mdu (iterative and fast multiplier
// builds) against an arithmetic reference model.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic flush;

  alu_mdu_if #(.WIDTH(32)) bus0 ();
  alu_mdu_if #(.WIDTH(32)) bus1 ();

  alu_mdu #(.WIDTH(32), .FAST_MUL(0)) dut_iter (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus0)
  );
  alu_mdu #(.WIDTH(32), .FAST_MUL(1)) dut_fast (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus1)
  );

  logic [1:0]  req_v;
  logic [1:0]  cons_rdy;
  logic [5:0]  req_op [2];
  logic [31:0] req_a  [2];
  logic [31:0] req_b  [2];
  logic [1:0]  obs_rdy;
  logic [1:0]  obs_v;
  logic [31:0] obs_res [2];

  assign bus0.valid_i = req_v[0];
  assign bus0.op_i    = req_op[0];
  assign bus0.a_i     = req_a[0];
  assign bus0.b_i     = req_b[0];
  assign bus0.ready_i = cons_rdy[0];
  assign bus1.valid_i = req_v[1];
  assign bus1.op_i    = req_op[1];
  assign bus1.a_i     = req_a[1];
  assign bus1.b_i     = req_b[1];
  assign bus1.ready_i = cons_rdy[1];
  assign obs_rdy[0]   = bus0.ready_o;
  assign obs_v[0]     = bus0.valid_o;
  assign obs_res[0]   = bus0.res_o;
  assign obs_rdy[1]   = bus1.ready_o;
  assign obs_v[1]     = bus1.valid_o;
  assign obs_res[1]   = bus1.res_o;

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_ALU_ADD:    return a + b;
      OP_ALU_SUB:    return a - b;
      OP_ALU_AND:    return a & b;
      OP_ALU_OR:     return a | b;
      OP_ALU_XOR:    return a ^ b;
      OP_ALU_SLL:    return a << b[4:0];
      OP_ALU_SRL:    return a >> b[4:0];
      OP_ALU_SRA:    return 32'(sa >>> b[4:0]);
      OP_ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      OP_ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      OP_MDU_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      OP_MDU_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MDU_MULHSU: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      OP_MDU_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_MDU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      OP_MDU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_MDU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      OP_MDU_REMU:   return (b == 0) ? a : a % b;
      default:       return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [5:0] op, input logic fast);
    if (op inside {OP_MDU_DIV, OP_MDU_DIVU, OP_MDU_REM, OP_MDU_REMU}) return 34;
    if (op inside {OP_MDU_MUL, OP_MDU_MULH, OP_MDU_MULHSU, OP_MDU_MULHU}) return fast ? 1 : 33;
    return 1;
  endfunction

  // Issues one op from an idle unit, checks latency, result, busy-phase ready
  // and stability under `hold` cycles of backpressure, then drains it.
  task automatic do_op(input int d, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int hold,
                       input string tag);
    int          lat;
    logic        busy_rdy;
    logic        unstable;
    logic [31:0] held;
    req_v[d]    = 1'b1;
    req_op[d]   = op;
    req_a[d]    = a;
    req_b[d]    = b;
    cons_rdy[d] = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_v[d]  = 1'b0;
    req_op[d] = 6'($urandom);
    req_a[d]  = $urandom;
    req_b[d]  = $urandom;
    lat = 1;
    busy_rdy = 1'b0;
    while (!obs_v[d] && lat < 100) begin
      busy_rdy |= obs_rdy[d];
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(ref_lat(op, d == 1)));
    check({tag, "_res"}, obs_res[d], exp);
    if (lat > 1) check({tag, "_busyrdy"}, busy_rdy, 0);
    held = obs_res[d];
    unstable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!obs_v[d] || obs_res[d] !== held || obs_rdy[d]) unstable = 1'b1;
    end
    if (hold > 0) check({tag, "_hold"}, unstable, 0);
    cons_rdy[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_drain"}, obs_v[d], 0);
  endtask

  logic [5:0]  bb_op  [3] = '{OP_ALU_ADD, OP_ALU_SUB, OP_ALU_SRA};
  logic [31:0] bb_a   [3] = '{32'd7, 32'd3, 32'h8000_0000};
  logic [31:0] bb_b   [3] = '{32'd5, 32'd5, 32'd4};
  logic [31:0] bb_exp [3] = '{32'd12, 32'hFFFF_FFFE, 32'hF800_0000};
  logic [5:0]  op_list [19] = '{OP_ALU_ADD, OP_ALU_SUB, OP_ALU_AND, OP_ALU_OR, OP_ALU_XOR,
                                OP_ALU_SLL, OP_ALU_SRL, OP_ALU_SRA, OP_ALU_SLT, OP_ALU_SLTU,
                                OP_MDU_MUL, OP_MDU_MULH, OP_MDU_MULHSU, OP_MDU_MULHU,
                                OP_MDU_DIV, OP_MDU_DIVU, OP_MDU_REM, OP_MDU_REMU, 6'h3F};
  logic [31:0] corner [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic        flag;
    int          lat;
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    req_v    = '0;
    cons_rdy = '0;
    for (int d = 0; d < 2; d++) begin
      req_op[d] = '0;
      req_a[d]  = '0;
      req_b[d]  = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", obs_rdy[d], 0);
      check("rst_valid", obs_v[d], 0);
      check("rst_res", obs_res[d], 0);
    end
    rst_n = 1'b1;
    #1;
    check("idle_ready", obs_rdy[0], 1);
    @(negedge clk);

    // Back-to-back single-cycle ops
    cons_rdy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_v[0] = 1'b1; req_op[0] = bb_op[i]; req_a[0] = bb_a[i]; req_b[0] = bb_b[i];
      #1;
      check("b2b_ready", obs_rdy[0], 1);
      @(posedge clk);
      @(negedge clk);
      check("b2b_valid", obs_v[0], 1);
      check("b2b_res", obs_res[0], bb_exp[i]);
    end
    req_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b2b_drain", obs_v[0], 0);

    // Signed divide and corner divides
    do_op(0, OP_MDU_DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 0, "div_m20_3");
    do_op(0, OP_MDU_REM,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 0, "rem_m20_3");
    do_op(0, OP_MDU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "divu_by0");
    do_op(0, OP_MDU_REM,  32'd5, 32'd0, 32'd5, 0, "rem_by0");
    do_op(0, OP_MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
    do_op(0, OP_MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "rem_ovf");

    // Multiplies on both builds
    for (int d = 0; d < 2; d++) begin
      do_op(d, OP_MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu");
      do_op(d, OP_MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, "mulh");
      do_op(d, OP_MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
      do_op(d, OP_MDU_MUL,    32'h0001_0000, 32'h0001_0000, 32'd0, 0, "mul");
    end

    // Backpressure after a divide, with a competing request held off
    req_v[0] = 1'b1; req_op[0] = OP_MDU_DIV; req_a[0] = 32'd100; req_b[0] = 32'd7;
    cons_rdy[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_v[0] = 1'b0;
    lat = 1;
    while (!obs_v[0] && lat < 100) begin @(negedge clk); lat++; end
    check("bp_div_res", obs_res[0], 32'd14);
    held = obs_res[0];
    req_v[0] = 1'b1; req_op[0] = OP_ALU_ADD; req_a[0] = 32'd1; req_b[0] = 32'd2;
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!obs_v[0] || obs_res[0] !== held || obs_rdy[0]) flag = 1'b1;
    end
    check("bp_stable", flag, 0);
    cons_rdy[0] = 1'b1;
    #1;
    check("bp_ready_rise", obs_rdy[0], 1);
    @(posedge clk);
    @(negedge clk);
    req_v[0] = 1'b0;
    check("bp_new_valid", obs_v[0], 1);
    check("bp_new_res", obs_res[0], 32'd3);
    @(posedge clk);
    @(negedge clk);
    check("bp_drain", obs_v[0], 0);

    // Request together with flush is refused
    flush = 1'b1;
    req_v[0] = 1'b1; req_op[0] = OP_ALU_ADD; req_a[0] = 32'd9; req_b[0] = 32'd9;
    #1;
    check("flush_idle_ready", obs_rdy[0], 0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    req_v[0] = 1'b0;
    check("flush_no_accept", obs_v[0], 0);

    // Flush mid-divide
    req_v[0] = 1'b1; req_op[0] = OP_MDU_DIV; req_a[0] = 32'd1000; req_b[0] = 32'd3;
    @(posedge clk);
    @(negedge clk);
    req_v[0] = 1'b0;
    flag = 1'b0;
    repeat (9) begin @(negedge clk); flag |= obs_v[0]; end
    flush = 1'b1;
    #1;
    check("flush_busy_ready", obs_rdy[0], 0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_ready_after", obs_rdy[0], 1);
    repeat (40) begin @(negedge clk); flag |= obs_v[0]; end
    check("flush_no_valid", flag, 0);
    do_op(0, OP_ALU_ADD, 32'd1, 32'd1, 32'd2, 0, "post_flush_add");

    // Reset mid-divide
    req_v[0] = 1'b1; req_op[0] = OP_MDU_DIV; req_a[0] = 32'd1000; req_b[0] = 32'd3;
    @(posedge clk);
    @(negedge clk);
    req_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", obs_rdy[0], 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_res", obs_res[0], 0);
    check("rst_mid_valid", obs_v[0], 0);
    rst_n = 1'b1;
    flag = 1'b0;
    repeat (40) begin @(negedge clk); flag |= obs_v[0]; end
    check("rst_no_valid", flag, 0);
    do_op(0, OP_ALU_ADD, 32'd1, 32'd1, 32'd2, 0, "post_rst_add");

    // Randomised ops against the reference model
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 120; n++) begin
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        op   = op_list[$urandom_range(0, 18)];
        a    = pick_operand();
        b    = pick_operand();
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        do_op(d, op, a, b, ref_res(op, a, b), hold, $sformatf("rnd%0d_op%0h", d, op));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
